// File: rtl/nand_pattern_checker.sv
// Gray-order stimulus and check stage for a single two-input NAND cell.
// Optional NANDCHK_XCHECK_EN (simulation only): X/Z on gate_q_i counts as a mismatch and sets x_seen_o.
module nand_pattern_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int COUNT_W       = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic               drive_a_o,
    output logic               drive_b_o,
    input  logic               gate_q_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [COUNT_W-1:0] err_count_o,
    output logic [3:0]         fail_vec_o
`ifdef NANDCHK_XCHECK_EN
    ,
    output logic               x_seen_o
`endif
);

    // state    | meaning
    // S_IDLE   | waiting for start
    // S_DRIVE  | new vector launched on drive_a/b
    // S_SETTLE | settle down-counter running
    // S_SAMPLE | gate_q compared on the edge leaving this state
    // S_DONE   | results held until restart or reset
    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [LW-1:0] LOOP_LAST   = LW'(LOOPS - 1);

    state_t               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [LW-1:0]        loop_q, loop_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic                 drive_a_q, drive_a_d;
    logic                 drive_b_q, drive_b_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [COUNT_W-1:0]   err_q, err_d;
    logic [3:0]           fail_q, fail_d;
    logic [1:0]           idx_nxt;
    logic                 exp_bit;
    logic                 mismatch;
`ifdef NANDCHK_XCHECK_EN
    logic                 x_seen_q, x_seen_d;
    logic                 q_is_xz;
`endif

    assign exp_bit = (idx_q != 2'd2);
    assign idx_nxt = idx_q + 2'd1;

`ifdef NANDCHK_XCHECK_EN
    assign q_is_xz  = (gate_q_i === 1'bx) || (gate_q_i === 1'bz);
    assign mismatch = (gate_q_i !== exp_bit);
`else
    assign mismatch = (gate_q_i != exp_bit);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            loop_q    <= '0;
            settle_q  <= '0;
            drive_a_q <= 1'b0;
            drive_b_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            fail_q    <= '0;
`ifdef NANDCHK_XCHECK_EN
            x_seen_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            loop_q    <= loop_d;
            settle_q  <= settle_d;
            drive_a_q <= drive_a_d;
            drive_b_q <= drive_b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
`ifdef NANDCHK_XCHECK_EN
            x_seen_q  <= x_seen_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        loop_d    = loop_q;
        settle_d  = settle_q;
        drive_a_d = drive_a_q;
        drive_b_d = drive_b_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_d     = err_q;
        fail_d    = fail_q;
`ifdef NANDCHK_XCHECK_EN
        x_seen_d  = x_seen_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d   = S_DRIVE;
                    idx_d     = '0;
                    loop_d    = '0;
                    err_d     = '0;
                    fail_d    = '0;
                    drive_a_d = 1'b0;
                    drive_b_d = 1'b0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
`ifdef NANDCHK_XCHECK_EN
                    x_seen_d  = 1'b0;
`endif
                end
            end
            S_DRIVE: begin
                if (SETTLE_CYCLES > 0) begin
                    state_d  = S_SETTLE;
                    settle_d = SETTLE_LOAD;
                end else begin
                    state_d = S_SAMPLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    fail_d[idx_q] = 1'b1;
                end
`ifdef NANDCHK_XCHECK_EN
                if (q_is_xz) begin
                    x_seen_d = 1'b1;
                end
`endif
                // Gray sequence 00,10,11,01: a = idx[1]^idx[0], b = idx[1]; wrap gives 00
                idx_d     = idx_nxt;
                drive_a_d = idx_nxt[1] ^ idx_nxt[0];
                drive_b_d = idx_nxt[1];
                state_d   = S_DRIVE;
                if (idx_q == 2'd3) begin
                    if (loop_q == LOOP_LAST) begin
                        state_d   = S_DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        pass_d    = (err_d == '0);
                        drive_a_d = 1'b0;
                        drive_b_d = 1'b0;
                    end else begin
                        loop_d = loop_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign drive_a_o   = drive_a_q;
    assign drive_b_o   = drive_b_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign fail_vec_o  = fail_q;
`ifdef NANDCHK_XCHECK_EN
    assign x_seen_o    = x_seen_q;
`endif

endmodule

// File: tb/tb_nand_pattern_checker.sv
// Self-checking bench: three checker instances driving modelled gates with fixed and random truth tables.
module tb_nand_pattern_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_v = 3'b000;
    logic [3:0] tt [3];

    always #5 clk = ~clk;

    logic       da0, db0, bz0, dn0, ps0, gq0;
    logic [7:0] ec0;
    logic [3:0] fv0;
    logic       da1, db1, bz1, dn1, ps1, gq1;
    logic [1:0] ec1;
    logic [3:0] fv1;
    logic       da2, db2, bz2, dn2, ps2, gq2;
    logic [7:0] ec2;
    logic [3:0] fv2;
`ifdef NANDCHK_XCHECK_EN
    logic       xs0, xs1, xs2;
`endif

    // gate index of the applied {a,b}: 00->0, 10->1, 11->2, 01->3
    function automatic int gate_idx(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    assign gq0 = tt[0][gate_idx(da0, db0)];
    assign gq1 = tt[1][gate_idx(da1, db1)];
    assign gq2 = tt[2][gate_idx(da2, db2)];

    nand_pattern_checker u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_v[0]),
        .drive_a_o(da0), .drive_b_o(db0), .gate_q_i(gq0),
        .busy_o(bz0), .done_o(dn0), .pass_o(ps0),
        .err_count_o(ec0), .fail_vec_o(fv0)
`ifdef NANDCHK_XCHECK_EN
        , .x_seen_o(xs0)
`endif
    );

    nand_pattern_checker #(.SETTLE_CYCLES(2), .LOOPS(3), .COUNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start_v[1]),
        .drive_a_o(da1), .drive_b_o(db1), .gate_q_i(gq1),
        .busy_o(bz1), .done_o(dn1), .pass_o(ps1),
        .err_count_o(ec1), .fail_vec_o(fv1)
`ifdef NANDCHK_XCHECK_EN
        , .x_seen_o(xs1)
`endif
    );

    nand_pattern_checker #(.SETTLE_CYCLES(0), .LOOPS(1), .COUNT_W(8)) u_fast (
        .clk_i(clk), .rst_i(rst), .start_i(start_v[2]),
        .drive_a_o(da2), .drive_b_o(db2), .gate_q_i(gq2),
        .busy_o(bz2), .done_o(dn2), .pass_o(ps2),
        .err_count_o(ec2), .fail_vec_o(fv2)
`ifdef NANDCHK_XCHECK_EN
        , .x_seen_o(xs2)
`endif
    );

    logic [2:0] da, db, bz, dn, ps;
    logic [7:0] ec [3];
    logic [3:0] fv [3];
    assign da = {da2, da1, da0};
    assign db = {db2, db1, db0};
    assign bz = {bz2, bz1, bz0};
    assign dn = {dn2, dn1, dn0};
    assign ps = {ps2, ps1, ps0};
    assign ec[0] = ec0;
    assign ec[1] = {6'b0, ec1};
    assign ec[2] = ec2;
    assign fv[0] = fv0;
    assign fv[1] = fv1;
    assign fv[2] = fv2;

    int per_c [3] = '{4, 4, 2};
    int loops [3] = '{1, 3, 1};
    int cnt_w [3] = '{8, 2, 8};

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] tt;
        logic [7:0] err;
        logic [3:0] fv;
        logic       pass;
        int         mid;
        string      nm;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: NAND truth table per vector is 1,1,0,1 (bit i = vector i)
    function automatic logic [3:0] miss_mask(input logic [3:0] t);
        return t ^ 4'b1011;
    endfunction

    function automatic logic [7:0] model_err(input logic [3:0] t, input int lp, input int cw);
        int n  = $countones(miss_mask(t)) * lp;
        int mx = (1 << cw) - 1;
        return 8'((n > mx) ? mx : n);
    endfunction

    function automatic logic vec_a(input int i);
        return (i == 1) || (i == 2);
    endfunction

    function automatic logic vec_b(input int i);
        return (i >= 2);
    endfunction

    task automatic check_idle(input string nm);
        for (int s = 0; s < 3; s++) begin
            chk({nm, " busy"}, 32'(bz[s]), 0);
            chk({nm, " done"}, 32'(dn[s]), 0);
            chk({nm, " pass"}, 32'(ps[s]), 0);
            chk({nm, " drives"}, {30'b0, da[s], db[s]}, 0);
            chk({nm, " err_count"}, 32'(ec[s]), 0);
            chk({nm, " fail_vec"}, 32'(fv[s]), 0);
        end
`ifdef NANDCHK_XCHECK_EN
        chk({nm, " x_seen"}, {29'b0, xs2, xs1, xs0}, 0);
`endif
    endtask

    task automatic run(input int s, input logic [3:0] t, input logic [7:0] e_err,
                       input logic [3:0] e_fv, input logic e_pass, input int mid, input string nm);
        int total;
        int vi;
        tt[s] = t;
        start_v[s] = 1'b1;
        @(posedge clk);
        #1;
        start_v[s] = 1'b0;
        total = 4 * loops[s] * per_c[s];
        for (int c = 0; c <= total; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            start_v[s] = (c + 1 == mid);
            if (c < total) begin
                vi = (c / per_c[s]) % 4;
                chk({nm, " drive_a"}, 32'(da[s]), 32'(vec_a(vi)));
                chk({nm, " drive_b"}, 32'(db[s]), 32'(vec_b(vi)));
                chk({nm, " busy"}, 32'(bz[s]), 1);
                chk({nm, " done early"}, 32'(dn[s]), 0);
            end else begin
                chk({nm, " done"}, 32'(dn[s]), 1);
                chk({nm, " busy end"}, 32'(bz[s]), 0);
                chk({nm, " drives end"}, {30'b0, da[s], db[s]}, 0);
                chk({nm, " err_count"}, 32'(ec[s]), 32'(e_err));
                chk({nm, " fail_vec"}, 32'(fv[s]), 32'(e_fv));
                chk({nm, " pass"}, 32'(ps[s]), 32'(e_pass));
            end
        end
        @(posedge clk);
        #1;
        chk({nm, " done held"}, 32'(dn[s]), 1);
        chk({nm, " err held"}, 32'(ec[s]), 32'(e_err));
    endtask

    initial begin
        logic [3:0] t;
        tt[0] = 4'b1011;
        tt[1] = 4'b1011;
        tt[2] = 4'b1011;

        tbl[0] = '{4'b1011, 8'd0, 4'b0000, 1'b1, 4,  "good"};
        tbl[1] = '{4'b1111, 8'd1, 4'b0100, 1'b0, 0,  "stuck1"};
        tbl[2] = '{4'b0000, 8'd3, 4'b1011, 1'b0, 0,  "stuck0"};
        for (int i = 3; i < 8; i++) begin
            t = 4'($urandom_range(0, 15));
            tbl[i] = '{t, model_err(t, 1, 8), miss_mask(t), (miss_mask(t) == 4'b0),
                       int'($urandom_range(0, 15)), "random"};
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle("idle");

        for (int i = 0; i < 8; i++) begin
            run(0, tbl[i].tt, tbl[i].err, tbl[i].fv, tbl[i].pass, tbl[i].mid, tbl[i].nm);
        end

        run(1, 4'b0000, 8'd3, 4'b1011, 1'b0, 20, "sat stuck0");
        for (int i = 0; i < 3; i++) begin
            t = 4'($urandom_range(0, 15));
            run(1, t, model_err(t, 3, 2), miss_mask(t), (miss_mask(t) == 4'b0), 0, "sat random");
        end

        run(2, 4'b1011, 8'd0, 4'b0000, 1'b1, 4, "fast good");
        t = 4'($urandom_range(0, 15));
        run(2, t, model_err(t, 1, 8), miss_mask(t), (miss_mask(t) == 4'b0), 0, "fast random");

        tt[0] = 4'b1011;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("mid-run reset");
        repeat (3) @(posedge clk);
        #1;
        check_idle("idle after abort");
        run(0, 4'b1011, 8'd0, 4'b0000, 1'b1, 0, "post-reset run");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
